// File: rtl/accum4_pkg.sv
// rtl/accum4_pkg.sv - shared opcode and FSM state encodings for accum4_seq
// Purpose: single home for the command opcodes and controller state encoding
//          used by the accumulator top and its bench.
// Contents: op_e (LOAD/ADD/SUB/CMP), state_e (IDLE/EXEC/RESP).
package accum4_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_CMP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/addsub4.sv
// rtl/addsub4.sv - two's complement adder/subtractor with signed overflow
// Purpose: sum = a + b (sub=0) or a + ~b + 1 (sub=1), modulo 2^WIDTH.
// Ports:
//   a, b  input  [WIDTH-1:0]  operands
//   sub   input              1 selects subtraction
//   sum   output [WIDTH-1:0]  result
//   ovf   output             carry into MSB xor carry out of MSB
module addsub4 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-2:0] low;
  logic             c_msb;
  logic             c_out;
  logic             msb;

  assign b_eff = sub ? ~b : b;

  // Split at the MSB so both the carry into and out of the top bit are visible.
  assign {c_msb, low} = {1'b0, a[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]}
                      + {{(WIDTH-1){1'b0}}, sub};
  assign {c_out, msb} = {1'b0, a[WIDTH-1]} + {1'b0, b_eff[WIDTH-1]} + {1'b0, c_msb};

  assign sum = {msb, low};
  assign ovf = c_msb ^ c_out;

endmodule

// File: rtl/accum4_seq.sv
// rtl/accum4_seq.sv - sequential accumulator with LOAD/ADD/SUB/CMP commands
// Purpose: accepts one command in IDLE, computes in EXEC, presents the result
//          in RESP until the consumer takes it.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     command handshake; in_op opcode, in_data operand
//   out_valid/out_ready   result handshake
//   out_acc               accumulator after the command
//   out_ovf, out_lt, out_eq  per-command flags
//   sticky_ovf            overflow seen since last LOAD or reset
module accum4_seq
  import accum4_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_acc,
  output logic             out_ovf,
  output logic             out_lt,
  output logic             out_eq,
  output logic             sticky_ovf
);

  state_e           state_q, state_d;
  op_e              op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] acc_q;
  logic             ovf_q, lt_q, eq_q, sticky_q;

  logic [WIDTH-1:0] as_sum;
  logic             as_ovf;

  // One shared datapath: only ADD adds, SUB and CMP both subtract.
  addsub4 #(.WIDTH(WIDTH)) u_addsub (
    .a   (acc_q),
    .b   (data_q),
    .sub (op_q != OP_ADD),
    .sum (as_sum),
    .ovf (as_ovf)
  );

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_LOAD;
      data_q   <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && in_valid) begin
        op_q   <= op_e'(in_op);
        data_q <= in_data;
      end
      // Results only move in EXEC, so they stay frozen through RESP.
      if (state_q == ST_EXEC) begin
        case (op_q)
          OP_LOAD: begin
            acc_q    <= data_q;
            ovf_q    <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            sticky_q <= 1'b0;
          end
          OP_ADD, OP_SUB: begin
            acc_q <= as_sum;
            ovf_q <= as_ovf;
            lt_q  <= 1'b0;
            eq_q  <= 1'b0;
            if (as_ovf) sticky_q <= 1'b1;
          end
          OP_CMP: begin
            ovf_q <= 1'b0;
            lt_q  <= as_sum[WIDTH-1] ^ as_ovf;
            eq_q  <= (as_sum == '0);
          end
          default: ;
        endcase
      end
    end
  end

  assign out_valid  = (state_q == ST_RESP);
  assign out_acc    = acc_q;
  assign out_ovf    = ovf_q;
  assign out_lt     = lt_q;
  assign out_eq     = eq_q;
  assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_accum4_seq.sv
// tb/tb_accum4_seq.sv - self-checking bench for accum4_seq
module tb_accum4_seq;
  import accum4_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_acc;
  logic       out_ovf, out_lt, out_eq, sticky_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (signed integer view of the accumulator)
  int m_acc;
  bit m_sticky;
  bit e_ovf, e_lt, e_eq;

  always #5 clk = ~clk;

  accum4_seq #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_acc    (out_acc),
    .out_ovf    (out_ovf),
    .out_lt     (out_lt),
    .out_eq     (out_eq),
    .sticky_ovf (sticky_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sx(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  function automatic logic [3:0] wrap(input int v);
    int r;
    r = ((v % 16) + 16) % 16;
    return r[3:0];
  endfunction

  // Update the model from the arithmetic definition of each opcode.
  task automatic model(input logic [1:0] op, input logic [3:0] d);
    int r;
    e_ovf = 0; e_lt = 0; e_eq = 0;
    case (op)
      2'b00: begin m_acc = sx(d); m_sticky = 0; end
      2'b01, 2'b10: begin
        r = (op == 2'b01) ? m_acc + sx(d) : m_acc - sx(d);
        e_ovf = (r > 7) || (r < -8);
        if (e_ovf) m_sticky = 1;
        m_acc = sx(wrap(r));
      end
      default: begin
        e_lt = m_acc < sx(d);
        e_eq = m_acc == sx(d);
      end
    endcase
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".acc"},    32'(out_acc),    32'(wrap(m_acc)));
    check({tag, ".ovf"},    32'(out_ovf),    32'(e_ovf));
    check({tag, ".lt"},     32'(out_lt),     32'(e_lt));
    check({tag, ".eq"},     32'(out_eq),     32'(e_eq));
    check({tag, ".sticky"}, 32'(sticky_ovf), 32'(m_sticky));
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] d, input int hold);
    logic [3:0] acc_seen;
    model(op, d);
    @(negedge clk);
    in_valid = 1; in_op = op; in_data = d;
    check("idle.rdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    check("exec.vld", 32'(out_valid), 32'd0);
    check("exec.rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("resp.vld", 32'(out_valid), 32'd1);
    check_outs("resp");
    acc_seen = out_acc;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1; in_op = 2'b00; in_data = ~d;
      @(negedge clk);
      check("hold.vld", 32'(out_valid), 32'd1);
      check("hold.rdy", 32'(in_ready), 32'd0);
      check("hold.acc", 32'(out_acc), 32'(acc_seen));
    end
    if (hold > 0) check_outs("held");
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("done.vld", 32'(out_valid), 32'd0);
    check("done.rdy", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_op = 0; in_data = 0; out_ready = 0;
    m_acc = 0; m_sticky = 0; e_ovf = 0; e_lt = 0; e_eq = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("rst.rdy", 32'(in_ready), 32'd1);
    check("rst.vld", 32'(out_valid), 32'd0);
    check_outs("rst");

    // Directed sequences
    run_cmd(2'b00, 4'd3, 0);
    run_cmd(2'b00, 4'd7, 0);
    run_cmd(2'b01, 4'd1, 0);
    check("ovf7p1.acc", 32'(out_acc), 32'h8);
    check("ovf7p1.sticky", 32'(sticky_ovf), 32'd1);
    run_cmd(2'b00, 4'd0, 0);
    check("load0.sticky", 32'(sticky_ovf), 32'd0);
    run_cmd(2'b00, 4'h8, 0);
    run_cmd(2'b10, 4'd1, 0);
    check("m8m1.acc", 32'(out_acc), 32'h7);
    check("m8m1.ovf", 32'(out_ovf), 32'd1);
    run_cmd(2'b00, 4'h8, 0);
    run_cmd(2'b11, 4'd1, 0);
    check("cmpm8.lt", 32'(out_lt), 32'd1);
    check("cmpm8.acc", 32'(out_acc), 32'h8);
    run_cmd(2'b00, 4'd5, 0);
    run_cmd(2'b11, 4'd5, 0);
    check("cmp55.eq", 32'(out_eq), 32'd1);
    run_cmd(2'b11, 4'hD, 4);
    check("cmp5m3.lt", 32'(out_lt), 32'd0);

    // Reset while in EXEC after an ADD
    @(negedge clk);
    in_valid = 1; in_op = 2'b01; in_data = 4'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    rst = 1;
    @(negedge clk);
    check("rexec.vld", 32'(out_valid), 32'd0);
    check("rexec.acc", 32'(out_acc), 32'd0);
    check("rexec.rdy", 32'(in_ready), 32'd1);
    rst = 0;
    m_acc = 0; m_sticky = 0; e_ovf = 0; e_lt = 0; e_eq = 0;
    @(negedge clk);
    check("rexec.rdy2", 32'(in_ready), 32'd1);
    check_outs("rexec");

    // Randomized commands
    for (int k = 0; k < 200; k++) begin
      run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accum4_seq.md
ACCUM4_SEQ -- requirements
Module: accum4_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and accumulator width in bits (two's complement).
REQ-002 The block SHALL have port clk  input  1  the single rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid  input  1  a command is offered.
REQ-005 The block SHALL have port in_ready  output  1  the block accepts a command this cycle.
REQ-006 The block SHALL have port in_op  input  2  opcode: 00 LOAD, 01 ADD, 10 SUB, 11 CMP.
REQ-007 The block SHALL have port in_data  input  WIDTH  operand.
REQ-008 The block SHALL have port out_valid  output  1  a result is presented.
REQ-009 The block SHALL have port out_ready  input  1  the consumer takes the result this cycle.
REQ-010 The block SHALL have port out_acc  output  WIDTH  accumulator value after the command.
REQ-011 The block SHALL have port out_ovf  output  1  signed overflow of this command.
REQ-012 The block SHALL have port out_lt  output  1  signed acc < in_data (CMP only, else 0).
REQ-013 The block SHALL have port out_eq  output  1  acc == in_data (CMP only, else 0).
REQ-014 The block SHALL have port sticky_ovf  output  1  overflow seen since the last LOAD or reset.

Function
REQ-015 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-016 in_ready SHALL be 1 exactly when state is IDLE; a command transfers on in_valid & in_ready.
REQ-017 On transfer in cycle N, opcode and operand SHALL be captured and the state SHALL be EXEC in N+1.
REQ-018 In EXEC the block SHALL compute and register results and move to RESP in N+2, with out_valid = 1 from N+2.
REQ-019 In RESP out_valid and all out_* SHALL stay stable until out_valid & out_ready, after which the state SHALL be IDLE in the next cycle.
REQ-020 LOAD SHALL set acc = in_data, out_ovf = 0, and clear sticky_ovf.
REQ-021 ADD SHALL set acc = acc + in_data modulo 2^WIDTH; SUB SHALL set acc = acc - in_data modulo 2^WIDTH, computed as acc + ~in_data + 1.
REQ-022 out_ovf SHALL equal the carry into the MSB XOR the carry out of the MSB of the add/sub.
REQ-023 CMP SHALL compute acc - in_data without changing acc, with out_lt = result MSB XOR overflow and out_eq = (difference == 0); out_ovf SHALL be 0 for CMP.
REQ-024 sticky_ovf SHALL be set in EXEC whenever ADD or SUB overflows and hold until LOAD or reset.
REQ-025 in_valid while not IDLE SHALL be ignored, with no capture; the upstream source holds it.
REQ-026 out_ready while not RESP SHALL be ignored.
REQ-027 Throughput SHALL be at most one command per three cycles; there is no internal queuing.

Reset
REQ-028 While rst = 1 at a clock edge, the state SHALL become IDLE and acc, out_acc, out_ovf, out_lt, out_eq, sticky_ovf and out_valid SHALL become 0.
REQ-029 Reset asserted during EXEC or RESP SHALL abort the command and drop any pending result without a transfer.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-031 The opcode encodings and the FSM state encoding SHALL live in shared package accum4_pkg.
REQ-032 The add/sub datapath SHALL be a single sub-module addsub4 (inputs a, b, sub; outputs sum, ovf), instantiated once and shared by ADD, SUB and CMP.

Verification
REQ-033 Reset, then LOAD 3 -> out_valid at transfer+2, out_acc = 3, out_ovf = 0, sticky_ovf = 0.
REQ-034 LOAD 7, ADD 1 -> out_acc = 1000b (-8), out_ovf = 1, sticky_ovf = 1; a following LOAD 0 clears sticky_ovf.
REQ-035 LOAD -8, SUB 1 -> out_acc = 0111b, out_ovf = 1; LOAD -8, CMP 1 -> out_lt = 1, out_eq = 0, acc stays -8.
REQ-036 LOAD 5, CMP 5 -> out_eq = 1, out_lt = 0; CMP -3 -> out_lt = 0.
REQ-037 Hold out_ready = 0 for 4 cycles in RESP -> out_* stable, in_ready = 0, new in_valid not captured; release -> IDLE next cycle.
REQ-038 Assert rst in EXEC after ADD -> next cycle out_valid = 0, acc = 0, in_ready = 1.
